// File: rtl/imem_program_loader.sv
// ---------------------------------------------------------------------------
// imem_program_loader
//
// Writer side of a byte-wide, big-endian instruction store. Instruction
// words arrive over a valid/ready stream and are split into four byte
// writes, most significant byte first, at consecutive addresses. A reader
// therefore finds instr[31:24] at the word's base address.
//
// The loader tracks the fill address and the number of completed words.
// It reports completion when the word flagged as last has been fully
// written. It reports overflow when the store fills before any word is
// flagged as last.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset, deasserted synchronously
//   start       one-cycle pulse; begins a new load at address 0
//   s_valid     instruction word valid
//   s_ready     loader can accept a word this cycle (registered, state only)
//   s_data      32-bit instruction word
//   s_last      marks s_data as the final word of the program
//   wr_en       byte write strobe to the instruction store (registered)
//   wr_addr     byte address of the write (registered)
//   wr_data     byte to write (registered)
//   busy        a load is in progress
//   done        program fully written; held until next start or reset
//   overflow    store filled without a last word; held until next start/reset
//   word_count  number of words fully written in the current load
// ---------------------------------------------------------------------------
module imem_program_loader #(
   parameter int ADDR_W      = 6,
   parameter int DEPTH_BYTES = 64,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [CNT_W-1:0]  word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        byte_idx;
   logic [23:0]       word_rest;
   logic              last_word;

   // The end-of-word address is computed one bit wider than the store
   // address so that filling the very last slot can be recognised without
   // the comparison wrapping back to zero.
   localparam logic [ADDR_W:0] DEPTH_END = (ADDR_W+1)'(DEPTH_BYTES);
   logic [ADDR_W:0]   addr_end;

   assign addr_end = {1'b0, addr} + (ADDR_W+1)'(4);

   // Single state machine with every output registered. The first byte of
   // a word is presented on the same edge that accepts the word; the
   // remaining three bytes come from a left-shifting copy of the low
   // 24 bits, so wr_data always takes the top byte of that copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         addr       <= '0;
         byte_idx   <= '0;
         word_rest  <= '0;
         last_word  <= 1'b0;
         s_ready    <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state      <= S_ACCEPT;
                  addr       <= '0;
                  word_count <= '0;
                  done       <= 1'b0;
                  overflow   <= 1'b0;
                  s_ready    <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            S_ACCEPT: begin
               if (s_valid && s_ready) begin
                  state     <= S_WRITE;
                  s_ready   <= 1'b0;
                  wr_en     <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= s_data[31:24];
                  word_rest <= s_data[23:0];
                  last_word <= s_last;
                  byte_idx  <= 2'd0;
               end
            end

            S_WRITE: begin
               if (byte_idx == 2'd3) begin
                  wr_en      <= 1'b0;
                  addr       <= addr_end[ADDR_W-1:0];
                  word_count <= word_count + CNT_W'(1);
                  if (last_word) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else if (addr_end == DEPTH_END) begin
                     state    <= S_ERR;
                     overflow <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state   <= S_ACCEPT;
                     s_ready <= 1'b1;
                  end
               end else begin
                  byte_idx  <= byte_idx + 2'd1;
                  wr_addr   <= wr_addr + ADDR_W'(1);
                  wr_data   <= word_rest[23:16];
                  word_rest <= {word_rest[15:0], 8'h00};
               end
            end

            default: begin
               state   <= S_IDLE;
               s_ready <= 1'b0;
               wr_en   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_program_loader
//
// Self-checking bench for imem_program_loader. Programs are described as a
// list of (word, last) pairs; a reference model derives the byte stream and
// final flags directly from the loader's rules, and a monitor records every
// byte write seen on the store interface for comparison.
// ---------------------------------------------------------------------------
module tb_imem_program_loader;

   localparam int ADDR_W      = 6;
   localparam int DEPTH_BYTES = 64;
   localparam int CNT_W       = 5;
   localparam int SLOTS       = DEPTH_BYTES / 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [31:0]       s_data = '0;
   logic              s_last = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [CNT_W-1:0]  word_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   imem_program_loader #(
      .ADDR_W      (ADDR_W),
      .DEPTH_BYTES (DEPTH_BYTES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte-write monitor, sampled on the falling edge.
   logic [ADDR_W-1:0] cap_addr[$];
   logic [7:0]        cap_data[$];
   int                cap_cyc[$];

   always @(negedge clk) begin
      if (wr_en) begin
         cap_addr.push_back(wr_addr);
         cap_data.push_back(wr_data);
         cap_cyc.push_back(cyc);
      end
   end

   // Program description and model expectations.
   logic [31:0]       prog_data[$];
   bit                prog_last[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [7:0]        exp_data[$];
   bit                exp_done;
   bit                exp_ovf;
   int                exp_words;

   // Reference model: each accepted word occupies the next 4-byte slot,
   // bytes in big-endian order; loading stops at the last-flagged word or
   // when all slots are used.
   task automatic build_model();
      exp_addr.delete();
      exp_data.delete();
      exp_done  = 1'b0;
      exp_ovf   = 1'b0;
      exp_words = 0;
      for (int j = 0; j < prog_data.size(); j++) begin
         if (exp_done || exp_ovf) break;
         for (int b = 0; b < 4; b++) begin
            exp_addr.push_back(ADDR_W'(4 * exp_words + b));
            exp_data.push_back(8'(prog_data[j] >> (24 - 8 * b)));
         end
         exp_words++;
         if (prog_last[j]) exp_done = 1'b1;
         else if (exp_words == SLOTS) exp_ovf = 1'b1;
      end
   endtask

   task automatic clear_capture();
      cap_addr.delete();
      cap_data.delete();
      cap_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input bit last, input int bound,
                            output bit ok, output int acc_cyc);
      ok      = 1'b0;
      acc_cyc = -1;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (ok) acc_cyc = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Reset, start, then stream the program; gap<0 selects random idle
   // cycles between words, during which s_last is toggled with s_valid low.
   task automatic run_program(input int gap, output int n_acc, output int first_acc);
      bit ok;
      int c;
      int g;
      do_reset();
      clear_capture();
      pulse_start();
      n_acc     = 0;
      first_acc = -1;
      for (int j = 0; j < prog_data.size(); j++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin
            s_last = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
         s_last = 1'b0;
         send_word(prog_data[j], prog_last[j], 20, ok, c);
         if (!ok) break;
         if (n_acc == 0) first_acc = c;
         n_acc++;
      end
      repeat (6) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++;
      if ({s_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {s_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({s_ready, busy, done, overflow} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_held got=%b want=0000", {s_ready, busy, done, overflow});
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({s_ready, busy} !== 2'b00) begin
         bad++;
         $display("FAIL idle_after_reset got=%b want=00", {s_ready, busy});
      end
   endtask

   task automatic test_single_word();
      int n_acc;
      int first_acc;
      prog_data = '{32'hF840_0182};
      prog_last = '{1'b1};
      build_model();
      run_program(0, n_acc, first_acc);
      total++;
      if (cap_addr.size() != exp_addr.size()) begin
         bad++;
         $display("FAIL single_len got=%0d want=%0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
         total++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            bad++;
            $display("FAIL single_byte%0d got=%0d:%h want=%0d:%h", i,
                     cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
         end
      end
      for (int i = 0; i < cap_cyc.size(); i++) begin
         total++;
         if (cap_cyc[i] !== first_acc + i) begin
            bad++;
            $display("FAIL single_timing%0d got=%0d want=%0d", i, cap_cyc[i], first_acc + i);
         end
      end
      total++;
      if ({done, overflow, busy, s_ready, word_count} !==
          {exp_done, exp_ovf, 1'b0, 1'b0, CNT_W'(exp_words)}) begin
         bad++;
         $display("FAIL single_flags got=%b want=%b",
                  {done, overflow, busy, s_ready, word_count},
                  {exp_done, exp_ovf, 1'b0, 1'b0, CNT_W'(exp_words)});
      end
   endtask

   task automatic test_full_program();
      int n_acc;
      int first_acc;
      prog_data.delete();
      prog_last.delete();
      for (int j = 0; j < SLOTS - 1; j++) begin
         prog_data.push_back($urandom);
         prog_last.push_back(1'b0);
      end
      prog_data.push_back(32'h1400_0014);
      prog_last.push_back(1'b1);
      build_model();
      run_program(0, n_acc, first_acc);
      total++;
      if (n_acc !== exp_words) begin
         bad++;
         $display("FAIL full_accepted got=%0d want=%0d", n_acc, exp_words);
      end
      total++;
      if (cap_addr.size() != exp_addr.size()) begin
         bad++;
         $display("FAIL full_len got=%0d want=%0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
         total++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            bad++;
            $display("FAIL full_byte%0d got=%0d:%h want=%0d:%h", i,
                     cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
         end
      end
      total++;
      if ({done, overflow, busy, word_count} !== {1'b1, 1'b0, 1'b0, CNT_W'(16)}) begin
         bad++;
         $display("FAIL full_flags got=%b want=%b", {done, overflow, busy, word_count},
                  {1'b1, 1'b0, 1'b0, CNT_W'(16)});
      end
   endtask

   task automatic test_overflow();
      int n_acc;
      int first_acc;
      prog_data.delete();
      prog_last.delete();
      for (int j = 0; j < SLOTS + 1; j++) begin
         prog_data.push_back($urandom);
         prog_last.push_back(1'b0);
      end
      build_model();
      run_program(0, n_acc, first_acc);
      total++;
      if (n_acc !== SLOTS) begin
         bad++;
         $display("FAIL ovf_accepted got=%0d want=%0d", n_acc, SLOTS);
      end
      total++;
      if (cap_addr.size() != exp_addr.size()) begin
         bad++;
         $display("FAIL ovf_len got=%0d want=%0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
         total++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            bad++;
            $display("FAIL ovf_byte%0d got=%0d:%h want=%0d:%h", i,
                     cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
         end
      end
      total++;
      if ({overflow, done, s_ready, busy, word_count} !==
          {exp_ovf, exp_done, 1'b0, 1'b0, CNT_W'(exp_words)}) begin
         bad++;
         $display("FAIL ovf_flags got=%b want=%b", {overflow, done, s_ready, busy, word_count},
                  {exp_ovf, exp_done, 1'b0, 1'b0, CNT_W'(exp_words)});
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int c;
      prog_data = '{$urandom, $urandom};
      prog_last = '{1'b0, 1'b1};
      build_model();
      do_reset();
      clear_capture();
      pulse_start();
      send_word(prog_data[0], prog_last[0], 20, ok, c);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept0 got=%b want=1", ok);
      end
      repeat (4) @(negedge clk);
      // ACCEPT with s_valid low: ready must stay up, no writes issued.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({s_ready, wr_en, busy} !== 3'b101) begin
            bad++;
            $display("FAIL bp_wait%0d got=%b want=101", i, {s_ready, wr_en, busy});
         end
      end
      @(posedge clk);
      #1;
      send_word(prog_data[1], prog_last[1], 20, ok, c);
      repeat (6) @(posedge clk);
      @(negedge clk);
      total++;
      if (cap_addr.size() != exp_addr.size()) begin
         bad++;
         $display("FAIL bp_len got=%0d want=%0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
         total++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            bad++;
            $display("FAIL bp_byte%0d got=%0d:%h want=%0d:%h", i,
                     cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
         end
      end
      total++;
      if ({done, word_count} !== {1'b1, CNT_W'(2)}) begin
         bad++;
         $display("FAIL bp_flags got=%b want=%b", {done, word_count}, {1'b1, CNT_W'(2)});
      end
   endtask

   task automatic test_reset_mid_word();
      bit ok;
      int c;
      do_reset();
      clear_capture();
      pulse_start();
      send_word(32'hAA01_0285, 1'b0, 20, ok, c);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (wr_en !== 1'b0) begin
         bad++;
         $display("FAIL midrst_wr_en got=%b want=0", wr_en);
      end
      total++;
      if ({s_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count} !== '0) begin
         bad++;
         $display("FAIL midrst_outputs got=%h want=0",
                  {s_ready, wr_en, wr_addr, wr_data, busy, done, overflow, word_count});
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      total++;
      if (cap_addr.size() != 2) begin
         bad++;
         $display("FAIL midrst_len got=%0d want=2", cap_addr.size());
      end else begin
         total++;
         if ({cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]} !==
             {ADDR_W'(0), 8'hAA, ADDR_W'(1), 8'h01}) begin
            bad++;
            $display("FAIL midrst_bytes got=%0d:%h %0d:%h want=0:aa 1:01",
                     cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]);
         end
      end
      clear_capture();
      pulse_start();
      send_word(32'h1122_3344, 1'b1, 20, ok, c);
      repeat (6) @(posedge clk);
      @(negedge clk);
      total++;
      if (cap_addr.size() != 4) begin
         bad++;
         $display("FAIL midrst_reload_len got=%0d want=4", cap_addr.size());
      end else begin
         total++;
         if ({cap_addr[0], cap_data[0], cap_addr[3], cap_data[3]} !==
             {ADDR_W'(0), 8'h11, ADDR_W'(3), 8'h44}) begin
            bad++;
            $display("FAIL midrst_reload got=%0d:%h %0d:%h want=0:11 3:44",
                     cap_addr[0], cap_data[0], cap_addr[3], cap_data[3]);
         end
      end
   endtask

   task automatic test_start_during_write();
      bit ok;
      int c;
      prog_data = '{$urandom, $urandom};
      prog_last = '{1'b0, 1'b1};
      build_model();
      do_reset();
      clear_capture();
      pulse_start();
      send_word(prog_data[0], prog_last[0], 20, ok, c);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      send_word(prog_data[1], prog_last[1], 20, ok, c);
      repeat (6) @(posedge clk);
      @(negedge clk);
      total++;
      if (cap_addr.size() != exp_addr.size()) begin
         bad++;
         $display("FAIL sdw_len got=%0d want=%0d", cap_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
         total++;
         if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            bad++;
            $display("FAIL sdw_byte%0d got=%0d:%h want=%0d:%h", i,
                     cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
         end
      end
      total++;
      if ({done, word_count} !== {1'b1, CNT_W'(2)}) begin
         bad++;
         $display("FAIL sdw_flags got=%b want=%b", {done, word_count}, {1'b1, CNT_W'(2)});
      end
   endtask

   task automatic test_random_programs();
      int n_acc;
      int first_acc;
      int len;
      int last_pos;
      for (int t = 0; t < 5; t++) begin
         len      = int'($urandom_range(1, 20));
         last_pos = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len - 1));
         prog_data.delete();
         prog_last.delete();
         for (int j = 0; j < len; j++) begin
            prog_data.push_back($urandom);
            prog_last.push_back(j == last_pos);
         end
         build_model();
         run_program(-1, n_acc, first_acc);
         total++;
         if (n_acc !== exp_words) begin
            bad++;
            $display("FAIL rnd%0d_accepted got=%0d want=%0d", t, n_acc, exp_words);
         end
         total++;
         if (cap_addr.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL rnd%0d_len got=%0d want=%0d", t, cap_addr.size(), exp_addr.size());
         end
         for (int i = 0; i < cap_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if ({cap_addr[i], cap_data[i]} !== {exp_addr[i], exp_data[i]}) begin
               bad++;
               $display("FAIL rnd%0d_byte%0d got=%0d:%h want=%0d:%h", t, i,
                        cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
         end
         total++;
         if ({done, overflow, busy, s_ready, word_count} !==
             {exp_done, exp_ovf, !(exp_done || exp_ovf), !(exp_done || exp_ovf),
              CNT_W'(exp_words)}) begin
            bad++;
            $display("FAIL rnd%0d_flags got=%b want=%b", t,
                     {done, overflow, busy, s_ready, word_count},
                     {exp_done, exp_ovf, !(exp_done || exp_ovf), !(exp_done || exp_ovf),
                      CNT_W'(exp_words)});
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_program();
      test_overflow();
      test_backpressure();
      test_reset_mid_word();
      test_start_during_write();
      test_random_programs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
